// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the two-requester memory bus arbiter.
// The arbitration policy is chosen by the MEM_ARB_RR_EN macro (see arb_pick2).
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWNER_IC = 1'b0,
        OWNER_DC = 1'b1
    } owner_e;

    // Transfer size encoding on *_size: bytes = 1 << size.
    typedef enum logic [1:0] {
        SIZE_1B = 2'd0,
        SIZE_2B = 2'd1,
        SIZE_4B = 2'd2,
        SIZE_8B = 2'd3
    } size_e;

    localparam logic OP_READ = 1'b0;

    function automatic owner_e owner_of(input logic grant_dc);
        return grant_dc ? OWNER_DC : OWNER_IC;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_pick2.sv
// Grant select between icache and dcache requests.
// MEM_ARB_RR_EN undefined: fixed priority, dcache wins; defined: round-robin.
import mem_bus_arbiter_pkg::*;

module arb_pick2 (
`ifdef MEM_ARB_RR_EN
    input  logic clk_i,
    input  logic rst_i,
    input  logic advance_i,
`endif
    input  logic ic_req_i,
    input  logic dc_req_i,
    output logic grant_dc_o
);

`ifdef MEM_ARB_RR_EN
    owner_e last_q;

    // On a tie the requester that was not granted last time wins.
    always_comb begin
        grant_dc_o = dc_req_i && (!ic_req_i || (last_q == OWNER_IC));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= OWNER_IC;
        end else if (advance_i) begin
            last_q <= owner_of(grant_dc_o);
        end
    end
`else
    logic unused_ic_req;

    always_comb begin
        grant_dc_o    = dc_req_i;
        unused_ic_req = ic_req_i;
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates icache and dcache onto one memory port, one transaction in flight.
// Policy: MEM_ARB_RR_EN defined -> round-robin, otherwise dcache has priority.
import mem_bus_arbiter_pkg::*;

module mem_bus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                ic_req_i,
    input  logic [ADDR_W-1:0]   ic_addr_i,
    output logic                ic_ready_o,
    output logic                ic_rvalid_o,
    output logic [DATA_W-1:0]   ic_rdata_o,

    input  logic                dc_req_i,
    input  logic                dc_op_i,
    input  logic [1:0]          dc_size_i,
    input  logic [ADDR_W-1:0]   dc_addr_i,
    input  logic [DATA_W-1:0]   dc_wdata_i,
    input  logic [DATA_W/8-1:0] dc_wstrb_i,
    output logic                dc_ready_o,
    output logic                dc_rvalid_o,
    output logic [DATA_W-1:0]   dc_rdata_o,

    output logic                mem_req_o,
    output logic                mem_op_o,
    output logic [1:0]          mem_size_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic                mem_ready_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int STRB_W = DATA_W / 8;

    state_e              state_q;
    owner_e              owner_q;
    logic                op_q,    op_d;
    logic [1:0]          size_q,  size_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;

    logic grant_dc;
    logic any_req;
    logic take_req;
    logic accept;
    logic respond;

    assign any_req  = ic_req_i || dc_req_i;
    assign take_req = (state_q == ST_IDLE) && any_req;

    arb_pick2 u_pick (
`ifdef MEM_ARB_RR_EN
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .advance_i  (take_req),
`endif
        .ic_req_i   (ic_req_i),
        .dc_req_i   (dc_req_i),
        .grant_dc_o (grant_dc)
    );

    // The icache is read-only, so its op/size/strobe are fixed rather than taken from ports.
    always_comb begin
        op_d    = OP_READ;
        size_d  = SIZE_8B;
        addr_d  = ic_addr_i;
        wdata_d = '0;
        wstrb_d = '0;
        if (grant_dc) begin
            op_d    = dc_op_i;
            size_d  = dc_size_i;
            addr_d  = dc_addr_i;
            wdata_d = dc_wdata_i;
            wstrb_d = dc_wstrb_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_IC;
            op_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        state_q <= ST_ISSUE;
                        owner_q <= owner_of(grant_dc);
                        op_q    <= op_d;
                        size_q  <= size_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        wstrb_q <= wstrb_d;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ready_i) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshakes are masked during reset so an aborted transaction never completes.
    assign accept  = !rst_i && (state_q == ST_ISSUE) && mem_ready_i;
    assign respond = !rst_i && (state_q == ST_WAIT) && mem_rvalid_i;

    assign ic_ready_o  = accept  && (owner_q == OWNER_IC);
    assign dc_ready_o  = accept  && (owner_q == OWNER_DC);
    assign ic_rvalid_o = respond && (owner_q == OWNER_IC);
    assign dc_rvalid_o = respond && (owner_q == OWNER_DC);
    assign ic_rdata_o  = ic_rvalid_o ? mem_rdata_i : '0;
    assign dc_rdata_o  = dc_rvalid_o ? mem_rdata_i : '0;

    assign mem_req_o   = !rst_i && (state_q == ST_ISSUE);
    assign mem_op_o    = op_q;
    assign mem_size_o  = size_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
// Works for both builds; the grant-order expectations follow MEM_ARB_RR_EN.
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic                ic_req;
    logic [ADDR_W-1:0]   ic_addr;
    logic                ic_ready, ic_rvalid;
    logic [DATA_W-1:0]   ic_rdata;
    logic                dc_req, dc_op;
    logic [1:0]          dc_size;
    logic [ADDR_W-1:0]   dc_addr;
    logic [DATA_W-1:0]   dc_wdata;
    logic [DATA_W/8-1:0] dc_wstrb;
    logic                dc_ready, dc_rvalid;
    logic [DATA_W-1:0]   dc_rdata;
    logic                mem_req, mem_op;
    logic [1:0]          mem_size;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic                mem_ready, mem_rvalid;
    logic [DATA_W-1:0]   mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .ic_req_i(ic_req), .ic_addr_i(ic_addr),
        .ic_ready_o(ic_ready), .ic_rvalid_o(ic_rvalid), .ic_rdata_o(ic_rdata),
        .dc_req_i(dc_req), .dc_op_i(dc_op), .dc_size_i(dc_size), .dc_addr_i(dc_addr),
        .dc_wdata_i(dc_wdata), .dc_wstrb_i(dc_wstrb),
        .dc_ready_o(dc_ready), .dc_rvalid_o(dc_rvalid), .dc_rdata_o(dc_rdata),
        .mem_req_o(mem_req), .mem_op_o(mem_op), .mem_size_o(mem_size), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
        .mem_ready_i(mem_ready), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    // Inputs change 1ns after the rising edge; outputs are checked 1ns later still.
    task tick;
        @(posedge clk);
        #1;
    endtask

    task clear_inputs;
        ic_req = 1'b0; ic_addr = '0;
        dc_req = 1'b0; dc_op = 1'b0; dc_size = 2'b00; dc_addr = '0; dc_wdata = '0; dc_wstrb = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task test_reset;
        clear_inputs();
        rst = 1'b1; ic_req = 1'b1; dc_req = 1'b1; dc_addr = 64'h55; mem_ready = 1'b1; mem_rvalid = 1'b1;
        tick(); tick();
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_req: got %0b expected 0", mem_req); end
        checks++; if ({ic_ready, dc_ready} !== 2'b00) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 00", {ic_ready, dc_ready}); end
        checks++; if ({ic_rvalid, dc_rvalid} !== 2'b00) begin failures++; $display("[TB] FAIL reset_rvalid: got %b expected 00", {ic_rvalid, dc_rvalid}); end
        checks++; if (mem_addr !== 64'h0) begin failures++; $display("[TB] FAIL reset_addr: got %h expected 0", mem_addr); end
        checks++; if ({mem_op, mem_size, mem_wstrb} !== 11'h0) begin failures++; $display("[TB] FAIL reset_fields: got %h expected 0", {mem_op, mem_size, mem_wstrb}); end
        clear_inputs();
        rst = 1'b0;
        tick();
    endtask

    task test_ic_read;
        ic_req = 1'b1; ic_addr = 64'h0000_0000_8000_0000;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL ic_idle_req: got %0b expected 0", mem_req); end
        tick();
        mem_ready = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("[TB] FAIL ic_issue_req: got %0b expected 1", mem_req); end
        checks++; if (mem_addr !== 64'h0000_0000_8000_0000) begin failures++; $display("[TB] FAIL ic_issue_addr: got %h expected 80000000", mem_addr); end
        checks++; if ({mem_op, mem_size} !== 3'b011) begin failures++; $display("[TB] FAIL ic_issue_opsize: got %b expected 011", {mem_op, mem_size}); end
        checks++; if (mem_wstrb !== 8'h00) begin failures++; $display("[TB] FAIL ic_issue_wstrb: got %h expected 00", mem_wstrb); end
        checks++; if ({ic_ready, dc_ready} !== 2'b10) begin failures++; $display("[TB] FAIL ic_accept: got %b expected 10", {ic_ready, dc_ready}); end
        tick();
        ic_req = 1'b0; mem_ready = 1'b0;
        #1;
        checks++; if ({mem_req, ic_ready} !== 2'b00) begin failures++; $display("[TB] FAIL ic_wait_req: got %b expected 00", {mem_req, ic_ready}); end
        tick();
        #1;
        checks++; if (ic_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL ic_early_rvalid: got %0b expected 0", ic_rvalid); end
        tick();
        mem_rvalid = 1'b1; mem_rdata = 64'h1234;
        #1;
        checks++; if ({ic_rvalid, dc_rvalid} !== 2'b10) begin failures++; $display("[TB] FAIL ic_rvalid: got %b expected 10", {ic_rvalid, dc_rvalid}); end
        checks++; if (ic_rdata !== 64'h1234) begin failures++; $display("[TB] FAIL ic_rdata: got %h expected 1234", ic_rdata); end
        tick();
        clear_inputs();
        #1;
        checks++; if ({ic_rvalid, mem_req} !== 2'b00) begin failures++; $display("[TB] FAIL ic_done: got %b expected 00", {ic_rvalid, mem_req}); end
    endtask

    task test_priority;
        ic_req = 1'b1; ic_addr = 64'h1000;
        dc_req = 1'b1; dc_addr = 64'h2000; dc_op = 1'b0; dc_size = 2'b10;
        tick();
        mem_ready = 1'b1;
        #1;
        checks++; if (mem_addr !== 64'h2000) begin failures++; $display("[TB] FAIL prio_first_addr: got %h expected 2000", mem_addr); end
        checks++; if (mem_size !== 2'b10) begin failures++; $display("[TB] FAIL prio_first_size: got %0d expected 2", mem_size); end
        checks++; if ({ic_ready, dc_ready} !== 2'b01) begin failures++; $display("[TB] FAIL prio_first_accept: got %b expected 01", {ic_ready, dc_ready}); end
        tick();
        dc_req = 1'b0; mem_ready = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 64'hAAAA;
        #1;
        checks++; if ({ic_rvalid, dc_rvalid} !== 2'b01) begin failures++; $display("[TB] FAIL prio_dc_rvalid: got %b expected 01", {ic_rvalid, dc_rvalid}); end
        checks++; if (dc_rdata !== 64'hAAAA) begin failures++; $display("[TB] FAIL prio_dc_rdata: got %h expected aaaa", dc_rdata); end
        tick();
        mem_rvalid = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL prio_idle_gap: got %0b expected 0", mem_req); end
        tick();
        mem_ready = 1'b1;
        #1;
        checks++; if ({mem_req, mem_addr} !== {1'b1, 64'h1000}) begin failures++; $display("[TB] FAIL prio_second_issue: got %0b/%h expected 1/1000", mem_req, mem_addr); end
        checks++; if ({ic_ready, dc_ready} !== 2'b10) begin failures++; $display("[TB] FAIL prio_second_accept: got %b expected 10", {ic_ready, dc_ready}); end
        tick();
        ic_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hBBBB;
        #1;
        checks++; if ({ic_rvalid, dc_rvalid} !== 2'b10) begin failures++; $display("[TB] FAIL prio_ic_rvalid: got %b expected 10", {ic_rvalid, dc_rvalid}); end
        tick();
        clear_inputs();
    endtask

    task test_back_to_back;
        logic exp_dc;
        ic_req = 1'b1; ic_addr = 64'h1000;
        dc_req = 1'b1; dc_addr = 64'h2000;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_dc = (i % 2 == 0);
`else
            exp_dc = 1'b1;
`endif
            tick();
            mem_ready = 1'b1;
            #1;
            checks++; if (mem_addr !== (exp_dc ? 64'h2000 : 64'h1000)) begin failures++; $display("[TB] FAIL b2b_addr[%0d]: got %h expected %h", i, mem_addr, exp_dc ? 64'h2000 : 64'h1000); end
            checks++; if ({ic_ready, dc_ready} !== {!exp_dc, exp_dc}) begin failures++; $display("[TB] FAIL b2b_accept[%0d]: got %b expected %b", i, {ic_ready, dc_ready}, {!exp_dc, exp_dc}); end
            tick();
            mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'(i + 16);
            #1;
            checks++; if ({ic_rvalid, dc_rvalid} !== {!exp_dc, exp_dc}) begin failures++; $display("[TB] FAIL b2b_rvalid[%0d]: got %b expected %b", i, {ic_rvalid, dc_rvalid}, {!exp_dc, exp_dc}); end
            tick();
            mem_rvalid = 1'b0;
        end
        clear_inputs();
        tick();
    endtask

    task test_write_stall;
        dc_req = 1'b1; dc_op = 1'b1; dc_size = 2'b10; dc_addr = 64'h3000;
        dc_wdata = 64'hDEAD_BEEF_CAFE_F00D; dc_wstrb = 8'h0F;
        tick();
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b0;
            mem_rvalid = (i == 2);
            #1;
            checks++; if ({mem_req, mem_op, mem_size, mem_wstrb} !== {1'b1, 1'b1, 2'b10, 8'h0F}) begin failures++; $display("[TB] FAIL stall_ctrl[%0d]: got %b expected 1110_00001111", i, {mem_req, mem_op, mem_size, mem_wstrb}); end
            checks++; if ({mem_addr, mem_wdata} !== {64'h3000, 64'hDEAD_BEEF_CAFE_F00D}) begin failures++; $display("[TB] FAIL stall_data[%0d]: got %h/%h expected 3000/deadbeefcafef00d", i, mem_addr, mem_wdata); end
            checks++; if ({dc_ready, dc_rvalid} !== 2'b00) begin failures++; $display("[TB] FAIL stall_pulses[%0d]: got %b expected 00", i, {dc_ready, dc_rvalid}); end
            tick();
        end
        mem_ready = 1'b1; mem_rvalid = 1'b1;
        #1;
        checks++; if ({dc_ready, dc_rvalid, ic_ready} !== 3'b100) begin failures++; $display("[TB] FAIL stall_accept: got %b expected 100", {dc_ready, dc_rvalid, ic_ready}); end
        tick();
        dc_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        #1;
        checks++; if ({mem_req, dc_ready} !== 2'b00) begin failures++; $display("[TB] FAIL stall_wait: got %b expected 00", {mem_req, dc_ready}); end
        tick();
        mem_rvalid = 1'b1;
        #1;
        checks++; if (dc_rvalid !== 1'b1) begin failures++; $display("[TB] FAIL stall_write_done: got %0b expected 1", dc_rvalid); end
        tick();
        clear_inputs();
    endtask

    task test_reset_in_wait;
        ic_req = 1'b1; ic_addr = 64'h4000;
        tick();
        mem_ready = 1'b1;
        tick();
        ic_req = 1'b0; mem_ready = 1'b0;
        rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h5555;
        #1;
        checks++; if ({ic_rvalid, dc_rvalid} !== 2'b00) begin failures++; $display("[TB] FAIL rstwait_during: got %b expected 00", {ic_rvalid, dc_rvalid}); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if ({ic_rvalid, dc_rvalid, mem_req} !== 3'b000) begin failures++; $display("[TB] FAIL rstwait_stale: got %b expected 000", {ic_rvalid, dc_rvalid, mem_req}); end
        tick();
        mem_rvalid = 1'b0; ic_req = 1'b1; ic_addr = 64'h4100;
        tick();
        mem_ready = 1'b1;
        #1;
        checks++; if ({mem_req, mem_addr, ic_ready} !== {1'b1, 64'h4100, 1'b1}) begin failures++; $display("[TB] FAIL rstwait_reissue: got %0b/%h/%0b expected 1/4100/1", mem_req, mem_addr, ic_ready); end
        tick();
        ic_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h77;
        #1;
        checks++; if ({ic_rvalid, ic_rdata} !== {1'b1, 64'h77}) begin failures++; $display("[TB] FAIL rstwait_complete: got %0b/%h expected 1/77", ic_rvalid, ic_rdata); end
        tick();
        clear_inputs();
    endtask

    task test_spurious_rvalid;
        mem_rvalid = 1'b1; mem_ready = 1'b1; mem_rdata = 64'hFFFF;
        #1;
        checks++; if ({ic_rvalid, dc_rvalid, ic_ready, dc_ready, mem_req} !== 5'b0) begin failures++; $display("[TB] FAIL spur_pulses: got %b expected 00000", {ic_rvalid, dc_rvalid, ic_ready, dc_ready, mem_req}); end
        tick();
        mem_rvalid = 1'b0; mem_ready = 1'b0;
        ic_req = 1'b1; ic_addr = 64'h5000;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL spur_still_idle: got %0b expected 0", mem_req); end
        tick();
        #1;
        checks++; if ({mem_req, mem_addr} !== {1'b1, 64'h5000}) begin failures++; $display("[TB] FAIL spur_then_issue: got %0b/%h expected 1/5000", mem_req, mem_addr); end
        mem_ready = 1'b1;
        tick();
        ic_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1;
        tick();
        clear_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_ic_read();
        test_priority();
        test_back_to_back();
        test_write_stall();
        test_reset_in_wait();
        test_spurious_rvalid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64: address width.
REQ-002 Parameter DATA_W, default 64: data width; wstrb width is DATA_W/8.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ic_req / ic_addr  in  1 / ADDR_W  icache read request (read-only requester).
REQ-006 ic_ready / ic_rvalid / ic_rdata  out  1 / 1 / DATA_W  accept pulse, response pulse, read data.
REQ-007 dc_req / dc_op / dc_size / dc_addr / dc_wdata / dc_wstrb  in  1 / 1 / 2 / ADDR_W / DATA_W / DATA_W/8  dcache request; op 1 = write.
REQ-008 dc_ready / dc_rvalid / dc_rdata  out  1 / 1 / DATA_W  accept pulse, response pulse, read data.
REQ-009 mem_req / mem_op / mem_size / mem_addr / mem_wdata / mem_wstrb  out  (as REQ-007)  downstream request.
REQ-010 mem_ready / mem_rvalid / mem_rdata  in  1 / 1 / DATA_W  downstream accept, response, data.

Function
REQ-011 FSM states: IDLE, ISSUE, WAIT; a registered owner field (IC/DC) is valid in ISSUE and WAIT.
REQ-012 IDLE: if any *_req=1, latch the winner's request fields and owner, go to ISSUE next cycle; no request -> stay IDLE.
REQ-013 Winner selection follows REQ-026/REQ-027; a single active requester always wins.
REQ-014 ISSUE: mem_req=1 with the latched fields; ic_op forced 0, ic_size forced 2'b11, ic_wstrb forced 0.
REQ-015 ISSUE and mem_ready=1: owner's *_ready pulses for exactly that cycle; go to WAIT.
REQ-016 WAIT: mem_req=0; on mem_rvalid=1, owner's *_rvalid pulses for one cycle with *_rdata=mem_rdata; go to IDLE.
REQ-017 mem_rvalid in IDLE or ISSUE is ignored; it produces no *_rvalid.
REQ-018 mem_rvalid and mem_ready both 1 in ISSUE: only mem_ready is acted on.
REQ-019 Writes complete via mem_rvalid like reads; dc_rdata is don't-care for writes.
REQ-020 Exactly one transaction outstanding; a requester holds *_req and fields stable until its *_ready; a *_req dropped after the latch does not cancel the issued transaction.
REQ-021 Minimum latency: req in cycle N -> mem_req in N+1 -> *_ready in N+1 if mem_ready=1 -> *_rvalid in the mem_rvalid cycle; back-to-back grant from IDLE the cycle after.
REQ-022 Non-owner *_ready and *_rvalid stay 0 at all times.

Reset
REQ-023 rst=1: state=IDLE, owner=IC, RR pointer=IC, mem_req=0, all *_ready/*_rvalid=0, latched fields=0.
REQ-024 rst mid-transaction aborts it without any ready/rvalid to either requester; a later stale mem_rvalid is dropped per REQ-017.

Configuration
REQ-025 Macro MEM_ARB_RR_EN selects the arbitration policy.
REQ-026 Without MEM_ARB_RR_EN: fixed priority, dcache over icache.
REQ-027 With MEM_ARB_RR_EN: round-robin; a one-bit pointer names the last granted requester and updates on each IDLE->ISSUE; on a tie the other requester wins.

Structure
REQ-028 Shared package holds the FSM state encoding, the owner encoding and the size encoding (0=1B, 1=2B, 2=4B, 3=8B).
REQ-029 One sub-module arb_pick2 (2-requester grant select, fixed or RR per macro); the rest is flat.

Verification
REQ-030 ic_req only, addr 0x8000_0000, mem_ready=1 at first ISSUE cycle, mem_rvalid 3 cycles later with rdata 0x1234 -> ic_ready 1 pulse, ic_rvalid 1 pulse with 0x1234, mem_op=0, mem_size=3.
REQ-031 ic_req and dc_req same cycle, no macro -> DC issued first, IC issued in the cycle after DC's rvalid returns to IDLE.
REQ-032 With MEM_ARB_RR_EN, both requesting continuously for 4 transactions -> grant order DC, IC, DC, IC.
REQ-033 dc write, wstrb 0x0F, mem_ready held 0 for 5 cycles -> mem_req and fields held stable for 5 cycles, dc_ready pulses only in the accept cycle.
REQ-034 rst asserted in WAIT, then mem_rvalid arrives -> no *_rvalid; the next ic_req completes normally.
REQ-035 Spurious mem_rvalid in IDLE -> no response pulse, state stays IDLE.
